ball_move_ctrl: RTL and testbench

- Per-frame ball motion sequencer for the 800x600 game screen.
- On each frame tick, computes a candidate ball position from the direction buttons.
- Checks all four corners of the candidate against the shared safe-map lookup port, arbitrated with the pixel renderer via a req/gnt handshake.
- Commits the move only if every corner is safe; otherwise holds position and flags a collision. Feeds the ball coordinates to the graphic block.

---
 rtl/ball_move_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ball_move_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_move_ctrl.sv
// ball_move_ctrl: per-frame ball motion sequencer with 4-corner safe-map probe.
// Optional BALL_MOVE_CTRL_SLIDE_EN: retry rejected diagonals as x-only then y-only.
module ball_move_ctrl #(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_SIZE     = 8,
    parameter int SPEED         = 2,
    parameter int MAP_LATENCY   = 1,
    parameter int START_X       = 16,
    parameter int START_Y       = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_frame_tick,
    input  logic                             i_left,
    input  logic                             i_right,
    input  logic                             i_up,
    input  logic                             i_down,
    output logic                             o_map_req,
    input  logic                             i_map_gnt,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  o_map_x,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] o_map_y,
    input  logic                             i_is_safe,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  o_ball_x,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] o_ball_y,
    output logic                             o_collision,
    output logic                             o_busy
);
    localparam int XW   = $clog2(SCREEN_WIDTH);
    localparam int YW   = $clog2(SCREEN_HEIGHT);
    localparam int CW   = ((XW > YW) ? XW : YW) + 2;
    localparam int LW   = (MAP_LATENCY > 1) ? $clog2(MAP_LATENCY + 1) : 1;
    localparam int MAXX = SCREEN_WIDTH - BALL_SIZE;
    localparam int MAXY = SCREEN_HEIGHT - BALL_SIZE;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_REQ, S_WAIT, S_EVAL, S_COMMIT
    } state_t;

    state_t          r_state, w_next;
    logic [XW-1:0]   r_ball_x, r_cx, r_map_x, w_cand_x;
    logic [YW-1:0]   r_ball_y, r_cy, r_map_y, w_cand_y;
    logic [1:0]      r_idx;
    logic [LW-1:0]   r_lat;
    logic            r_safe, r_collision;
    logic signed [CW-1:0] w_dx, w_dy, w_sx, w_sy;
    logic            w_same, w_retry;

`ifdef BALL_MOVE_CTRL_SLIDE_EN
    logic [1:0]      r_attempt;
    logic [YW-1:0]   r_fy;
    logic            r_diag;
    assign w_retry = r_diag && (r_attempt != 2'd2);
`else
    assign w_retry = 1'b0;
`endif

    function automatic logic [XW-1:0] f_cx(input logic [XW-1:0] x, input logic [1:0] idx);
        return idx[0] ? x + XW'(BALL_SIZE - 1) : x;
    endfunction

    function automatic logic [YW-1:0] f_cy(input logic [YW-1:0] y, input logic [1:0] idx);
        return idx[1] ? y + YW'(BALL_SIZE - 1) : y;
    endfunction

    assign o_map_req   = (r_state == S_REQ);
    assign o_busy      = (r_state != S_IDLE);
    assign o_map_x     = r_map_x;
    assign o_map_y     = r_map_y;
    assign o_ball_x    = r_ball_x;
    assign o_ball_y    = r_ball_y;
    assign o_collision = r_collision;

    // Candidate position: signed step from the buttons, clamped to the screen.
    always_comb begin
        w_dx = '0;
        w_dy = '0;
        if (i_right && !i_left) w_dx = CW'(SPEED);
        else if (i_left && !i_right) w_dx = -CW'(SPEED);
        if (i_down && !i_up) w_dy = CW'(SPEED);
        else if (i_up && !i_down) w_dy = -CW'(SPEED);
        w_sx = $signed(CW'(r_ball_x)) + w_dx;
        w_sy = $signed(CW'(r_ball_y)) + w_dy;
        if (w_sx < 0) w_cand_x = '0;
        else if (w_sx > CW'(MAXX)) w_cand_x = XW'(MAXX);
        else w_cand_x = w_sx[XW-1:0];
        if (w_sy < 0) w_cand_y = '0;
        else if (w_sy > CW'(MAXY)) w_cand_y = YW'(MAXY);
        else w_cand_y = w_sy[YW-1:0];
        w_same = (w_cand_x == r_ball_x) && (w_cand_y == r_ball_y);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (i_frame_tick) w_next = S_CALC;
            S_CALC:   w_next = w_same ? S_IDLE : S_REQ;
            S_REQ:    if (i_map_gnt) w_next = S_WAIT;
            S_WAIT:   if (r_lat == LW'(1)) w_next = S_EVAL;
            S_EVAL: begin
                if (!r_safe)              w_next = w_retry ? S_REQ : S_IDLE;
                else if (r_idx == 2'd3)   w_next = S_COMMIT;
                else                      w_next = S_REQ;
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath: candidate, probe address, latency count, result and commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ball_x    <= XW'(START_X);
            r_ball_y    <= YW'(START_Y);
            r_cx        <= '0;
            r_cy        <= '0;
            r_map_x     <= '0;
            r_map_y     <= '0;
            r_idx       <= '0;
            r_lat       <= '0;
            r_safe      <= 1'b0;
            r_collision <= 1'b0;
`ifdef BALL_MOVE_CTRL_SLIDE_EN
            r_attempt   <= '0;
            r_fy        <= '0;
            r_diag      <= 1'b0;
`endif
        end else begin
            r_collision <= 1'b0;
            unique case (r_state)
                S_CALC: begin
                    r_cx    <= w_cand_x;
                    r_cy    <= w_cand_y;
                    r_map_x <= w_cand_x;
                    r_map_y <= w_cand_y;
                    r_idx   <= '0;
`ifdef BALL_MOVE_CTRL_SLIDE_EN
                    r_attempt <= '0;
                    r_fy      <= w_cand_y;
                    r_diag    <= (w_dx != '0) && (w_dy != '0);
`endif
                end
                S_REQ: begin
                    if (i_map_gnt) r_lat <= LW'(MAP_LATENCY);
                end
                S_WAIT: begin
                    if (r_lat == LW'(1)) r_safe <= i_is_safe;
                    else                 r_lat  <= r_lat - 1'b1;
                end
                S_EVAL: begin
                    if (r_safe) begin
                        if (r_idx != 2'd3) begin
                            r_idx   <= r_idx + 2'd1;
                            r_map_x <= f_cx(r_cx, r_idx + 2'd1);
                            r_map_y <= f_cy(r_cy, r_idx + 2'd1);
                        end
                    end
`ifdef BALL_MOVE_CTRL_SLIDE_EN
                    else if (w_retry) begin
                        r_attempt <= r_attempt + 2'd1;
                        r_idx     <= '0;
                        if (r_attempt == 2'd0) begin
                            r_cy    <= r_ball_y;
                            r_map_x <= r_cx;
                            r_map_y <= r_ball_y;
                        end else begin
                            r_cx    <= r_ball_x;
                            r_cy    <= r_fy;
                            r_map_x <= r_ball_x;
                            r_map_y <= r_fy;
                        end
                    end
`endif
                    else begin
                        r_collision <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_ball_x <= r_cx;
                    r_ball_y <= r_cy;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_move_ctrl.sv
// tb_ball_move_ctrl: scoreboard bench for ball_move_ctrl.
// Expected probe addresses are queued at stimulus time and popped per grant.
module tb_ball_move_ctrl;
`ifdef BALL_MOVE_CTRL_SLIDE_EN
    localparam bit SLIDE = 1'b1;
`else
    localparam bit SLIDE = 1'b0;
`endif
    localparam int LAT_BEST = 2 + 4 * (1 + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0, tick_c = 1'b0;
    logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
    logic gnt = 1'b0;
    logic req, req_c, coll, coll_c, busy, busy_c, safe;
    logic [9:0] mx, my, bx, by, mxc, myc, bxc, byc;

    logic       u_en = 1'b0;
    logic [9:0] ux0 = '0, ux1 = '0, uy0 = '0, uy1 = '0;

    int checks = 0, failures = 0, n_coll = 0, n_coll_c = 0;
    logic [19:0] q[$];
    logic [19:0] qc[$];

    always #5 clk = ~clk;

    assign safe = !(u_en && mx >= ux0 && mx <= ux1 && my >= uy0 && my <= uy1);

    ball_move_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(tick),
        .i_left(bl), .i_right(br), .i_up(bu), .i_down(bd),
        .o_map_req(req), .i_map_gnt(gnt), .o_map_x(mx), .o_map_y(my),
        .i_is_safe(safe), .o_ball_x(bx), .o_ball_y(by),
        .o_collision(coll), .o_busy(busy)
    );

    ball_move_ctrl #(.START_X(791), .START_Y(300)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(tick_c),
        .i_left(bl), .i_right(br), .i_up(bu), .i_down(bd),
        .o_map_req(req_c), .i_map_gnt(gnt), .o_map_x(mxc), .o_map_y(myc),
        .i_is_safe(1'b1), .o_ball_x(bxc), .o_ball_y(byc),
        .o_collision(coll_c), .o_busy(busy_c)
    );

    // Scoreboard pop: one expected address per accepted grant.
    always @(negedge clk) begin
        if (rst_n && req && gnt) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL probe_unexpected got=(%0d,%0d) want=none", mx, my);
            end else begin
                logic [19:0] e;
                e = q.pop_front();
                if ({mx, my} !== e) begin
                    failures++;
                    $display("FAIL probe_addr got=(%0d,%0d) want=(%0d,%0d)",
                             mx, my, e[19:10], e[9:0]);
                end
            end
        end
        if (rst_n && req_c && gnt) begin
            checks++;
            if (qc.size() == 0) begin
                failures++;
                $display("FAIL probe_c_unexpected got=(%0d,%0d) want=none", mxc, myc);
            end else begin
                logic [19:0] e;
                e = qc.pop_front();
                if ({mxc, myc} !== e) begin
                    failures++;
                    $display("FAIL probe_c_addr got=(%0d,%0d) want=(%0d,%0d)",
                             mxc, myc, e[19:10], e[9:0]);
                end
            end
        end
        if (coll)   n_coll++;
        if (coll_c) n_coll_c++;
    end

    function automatic bit map_safe(input logic [9:0] x, input logic [9:0] y);
        return !(u_en && x >= ux0 && x <= ux1 && y >= uy0 && y <= uy1);
    endfunction

    task automatic probe(input int cx, input int cy, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int x, y;
            x = cx + (((i % 2) == 1) ? 7 : 0);
            y = cy + ((i >= 2) ? 7 : 0);
            q.push_back({10'(x), 10'(y)});
            if (!map_safe(10'(x), 10'(y))) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic model_move(input int bx0, input int by0, input int dx, input int dy);
        int fx, fy;
        bit ok;
        fx = bx0 + dx;
        fy = by0 + dy;
        if (fx < 0) fx = 0;
        if (fx > 792) fx = 792;
        if (fy < 0) fy = 0;
        if (fy > 592) fy = 592;
        if (fx == bx0 && fy == by0) return;
        probe(fx, fy, ok);
        if (ok) return;
        if (SLIDE && dx != 0 && dy != 0) begin
            probe(fx, by0, ok);
            if (ok) return;
            probe(bx0, fy, ok);
        end
    endtask

    task automatic pulse_tick(input bit c);
        @(posedge clk);
        #1;
        if (c) tick_c = 1'b1; else tick = 1'b1;
        @(posedge clk);
        #1;
        tick_c = 1'b0;
        tick = 1'b0;
    endtask

    task automatic wait_idle(input bit c, input int maxc, output int lat, output bit done);
        lat = 0;
        done = 1'b0;
        while (lat < maxc) begin
            @(negedge clk);
            lat++;
            if (!(c ? busy_c : busy)) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        bit done;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bx, by} !== {10'd16, 10'd16}) begin
            failures++;
            $display("FAIL reset_ball got=(%0d,%0d) want=(16,16)", bx, by);
        end
        checks++;
        if ({req, coll, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got req/coll/busy=%b want=000", {req, coll, busy});
        end
        checks++;
        if ({mx, my} !== 20'd0) begin
            failures++;
            $display("FAIL reset_map got=(%0d,%0d) want=(0,0)", mx, my);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        gnt = 1'b1;
        pulse_tick(1'b0);
        wait_idle(1'b0, 10, lat, done);
        checks++;
        if (!done || lat != 2) begin
            failures++;
            $display("FAIL idle_tick_busy got=%0d cycles want=2", lat);
        end
        checks++;
        if ({bx, by, coll} !== {10'd16, 10'd16, 1'b0}) begin
            failures++;
            $display("FAIL idle_tick_ball got=(%0d,%0d,c%0d) want=(16,16,c0)", bx, by, coll);
        end
    endtask

    task automatic test_collision();
        int lat, c0;
        bit done;
        c0 = n_coll;
        bd = 1'b1;
        u_en = 1'b1;
        ux0 = 10'd16; ux1 = 10'd16; uy0 = 10'd25; uy1 = 10'd25;
        model_move(16, 16, 0, 2);
        pulse_tick(1'b0);
        wait_idle(1'b0, 60, lat, done);
        repeat (2) @(negedge clk);
        checks++;
        if (!done || q.size() != 0) begin
            failures++;
            $display("FAIL coll_probes got done=%0d left=%0d want done=1 left=0", done, q.size());
        end
        checks++;
        if (n_coll - c0 != 1) begin
            failures++;
            $display("FAIL coll_pulse got=%0d want=1", n_coll - c0);
        end
        checks++;
        if ({bx, by} !== {10'd16, 10'd16}) begin
            failures++;
            $display("FAIL coll_ball got=(%0d,%0d) want=(16,16)", bx, by);
        end
        bd = 1'b0;
        u_en = 1'b0;
    endtask

    task automatic test_right();
        int lat, c0;
        bit done;
        c0 = n_coll;
        br = 1'b1;
        q.push_back({10'd18, 10'd16});
        q.push_back({10'd25, 10'd16});
        q.push_back({10'd18, 10'd23});
        q.push_back({10'd25, 10'd23});
        pulse_tick(1'b0);
        wait_idle(1'b0, 60, lat, done);
        checks++;
        if (!done || lat != LAT_BEST + 1) begin
            failures++;
            $display("FAIL right_latency got=%0d want=%0d", lat, LAT_BEST + 1);
        end
        checks++;
        if ({bx, by} !== {10'd18, 10'd16}) begin
            failures++;
            $display("FAIL right_ball got=(%0d,%0d) want=(18,16)", bx, by);
        end
        checks++;
        if (q.size() != 0 || n_coll != c0) begin
            failures++;
            $display("FAIL right_probes got left=%0d coll=%0d want 0/0", q.size(), n_coll - c0);
        end
        br = 1'b0;
    endtask

    task automatic test_clamp();
        int lat;
        bit done;
        br = 1'b1;
        qc.push_back({10'd792, 10'd300});
        qc.push_back({10'd799, 10'd300});
        qc.push_back({10'd792, 10'd307});
        qc.push_back({10'd799, 10'd307});
        pulse_tick(1'b1);
        wait_idle(1'b1, 60, lat, done);
        checks++;
        if (!done || {bxc, byc} !== {10'd792, 10'd300} || qc.size() != 0) begin
            failures++;
            $display("FAIL clamp_ball got=(%0d,%0d) left=%0d want=(792,300) left=0",
                     bxc, byc, qc.size());
        end
        pulse_tick(1'b1);
        wait_idle(1'b1, 10, lat, done);
        repeat (2) @(negedge clk);
        checks++;
        if (!done || lat != 2 || n_coll_c != 0) begin
            failures++;
            $display("FAIL clamp_edge got cycles=%0d coll=%0d want 2/0", lat, n_coll_c);
        end
        checks++;
        if ({bxc, byc} !== {10'd792, 10'd300}) begin
            failures++;
            $display("FAIL clamp_hold got=(%0d,%0d) want=(792,300)", bxc, byc);
        end
        br = 1'b0;
    endtask

    task automatic test_stall();
        int lat, k;
        bit done;
        bl = 1'b1;
        gnt = 1'b0;
        model_move(18, 16, -2, 0);
        pulse_tick(1'b0);
        k = 0;
        while (!req && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!req) begin
            failures++;
            $display("FAIL stall_req_rise got=0 want=1");
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tick = (i == 5);
            checks++;
            if ({req, mx, my} !== {1'b1, 10'd16, 10'd16}) begin
                failures++;
                $display("FAIL stall_hold got req=%0d (%0d,%0d) want req=1 (16,16)", req, mx, my);
            end
        end
        tick = 1'b0;
        @(posedge clk);
        #1 gnt = 1'b1;
        wait_idle(1'b0, 60, lat, done);
        repeat (5) @(negedge clk);
        checks++;
        if (!done || busy !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL stall_drop got done=%0d busy=%0d left=%0d want 1/0/0",
                     done, busy, q.size());
        end
        checks++;
        if ({bx, by} !== {10'd16, 10'd16}) begin
            failures++;
            $display("FAIL stall_ball got=(%0d,%0d) want=(16,16)", bx, by);
        end
        bl = 1'b0;
    endtask

    task automatic test_diag();
        int lat, c0;
        bit done;
        c0 = n_coll;
        br = 1'b1;
        bd = 1'b1;
        u_en = 1'b1;
        ux0 = 10'd24; ux1 = 10'd1023; uy0 = 10'd24; uy1 = 10'd1023;
        model_move(16, 16, 2, 2);
        pulse_tick(1'b0);
        wait_idle(1'b0, 120, lat, done);
        repeat (2) @(negedge clk);
        checks++;
        if (!done || q.size() != 0) begin
            failures++;
            $display("FAIL diag_probes got done=%0d left=%0d want 1/0", done, q.size());
        end
`ifdef BALL_MOVE_CTRL_SLIDE_EN
        checks++;
        if ({bx, by} !== {10'd18, 10'd16} || n_coll != c0) begin
            failures++;
            $display("FAIL slide_x got=(%0d,%0d) coll=%0d want=(18,16) coll=0",
                     bx, by, n_coll - c0);
        end
        ux0 = 10'd26; uy0 = 10'd0;
        model_move(18, 16, 2, 2);
        pulse_tick(1'b0);
        wait_idle(1'b0, 120, lat, done);
        repeat (2) @(negedge clk);
        checks++;
        if (!done || q.size() != 0 || {bx, by} !== {10'd18, 10'd18} || n_coll != c0) begin
            failures++;
            $display("FAIL slide_y got=(%0d,%0d) left=%0d coll=%0d want=(18,18) 0/0",
                     bx, by, q.size(), n_coll - c0);
        end
`else
        checks++;
        if ({bx, by} !== {10'd16, 10'd16} || n_coll - c0 != 1) begin
            failures++;
            $display("FAIL diag_reject got=(%0d,%0d) coll=%0d want=(16,16) coll=1",
                     bx, by, n_coll - c0);
        end
`endif
        br = 1'b0;
        bd = 1'b0;
        u_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        bit seen;
        bu = 1'b1;
        gnt = 1'b0;
        pulse_tick(1'b0);
        k = 0;
        seen = 1'b0;
        while (k < 10 && !seen) begin
            @(negedge clk);
            k++;
            seen = req;
        end
        #3 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || {req, busy} !== 2'b00 || {bx, by} !== {10'd16, 10'd16}) begin
            failures++;
            $display("FAIL mid_reset got seen=%0d req=%0d busy=%0d (%0d,%0d) want 1/0/0 (16,16)",
                     seen, req, busy, bx, by);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        gnt = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || {bx, by} !== {10'd16, 10'd16}) begin
            failures++;
            $display("FAIL mid_reset_after got busy=%0d (%0d,%0d) want 0 (16,16)", busy, bx, by);
        end
        bu = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_collision();
        test_right();
        test_clamp();
        test_stall();
        test_diag();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
